// File: rtl/led_chaser_debug_pkg.sv
// Shared definitions for the Led_chaser on-chip debug memory: jdo field
// positions, RAM geometry and the controller's state/command encodings.
package led_chaser_debug_pkg;

  localparam int RAM_AW = 8;

  localparam int SET_ADDR = 17;
  localparam int RD       = 34;
  localparam int ADDR_HI  = 33;
  localparam int ADDR_LO  = 26;
  localparam int WDATA_HI = 34;
  localparam int WDATA_LO = 3;

  typedef enum logic [1:0] {
    IDLE,
    J_RD,
    J_CAP,
    C_RD
  } ocimem_state_t;

  typedef enum logic [1:0] {
    CMD_RD,
    CMD_WR,
    CMD_SETA
  } jtag_cmd_t;

endpackage

// File: rtl/led_chaser_ocimem_ram.sv
// Single-port debug RAM, 32-bit words with byte-lane writes and a registered
// read port (data appears the cycle after the read is issued).
module led_chaser_ocimem_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we == 4'b0000) rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/led_chaser_ocimem_ctrl.sv
// Debug-RAM arbiter between JTAG monitor commands (via a 1-entry pending
// register) and the CPU Avalon debug slave.
//
// state | meaning
// IDLE  | service pending JTAG command, else accept a CPU access
// J_RD  | JTAG read data on RAM output, captured into MonDReg
// J_CAP | post-increment monitor address after a JTAG read
// C_RD  | CPU read data on RAM output, captured into readdata
module led_chaser_ocimem_ctrl
  import led_chaser_debug_pkg::*;
#(
  parameter int RAM_AW = led_chaser_debug_pkg::RAM_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [RAM_AW-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic [RAM_AW+1:0] MonAReg,
  output logic              ocimem_overrun
);

  ocimem_state_t     state;
  jtag_cmd_t         pend_cmd;
  logic              pend_valid;
  logic              pend_set;
  logic [RAM_AW-1:0] pend_addr;
  logic [31:0]       pend_data;
  logic [RAM_AW-1:0] mon_addr;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [RAM_AW-1:0] jdo_addr;
  logic [31:0]       jdo_data;
  logic [RAM_AW-1:0] jtag_addr;
  logic              cpu_wr_go;
  logic              cpu_rd_go;
  logic              strobe_lost;
  logic              jdo_unused;

  assign jdo_addr   = RAM_AW'(jdo[ADDR_HI:ADDR_LO]);
  assign jdo_data   = jdo[WDATA_HI:WDATA_LO];
  assign jdo_unused = ^{jdo[37:35], jdo[2:0]};
  assign jtag_addr  = pend_set ? pend_addr : mon_addr;

  assign cpu_wr_go   = (state == IDLE) && !pend_valid && write;
  assign cpu_rd_go   = (state == IDLE) && !pend_valid && read && !write;
  assign waitrequest = (read || write) && !(cpu_wr_go || (state == C_RD));
  assign MonAReg     = {mon_addr, 2'b00};

  // Priority a > no_action > b; anything not taken is reported as overrun.
  assign strobe_lost =
      (pend_valid && (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b)) ||
      (take_action_ocimem_a && (take_no_action_ocimem_a || take_action_ocimem_b)) ||
      (take_no_action_ocimem_a && take_action_ocimem_b);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = mon_addr;
    ram_wdata = pend_data;
    if (state == IDLE) begin
      if (pend_valid) begin
        if (pend_cmd == CMD_RD) begin
          ram_en   = 1'b1;
          ram_addr = jtag_addr;
        end else if (pend_cmd == CMD_WR) begin
          ram_en = 1'b1;
          ram_we = 4'b1111;
        end
      end else if (cpu_wr_go) begin
        ram_we    = byteenable & {4{debugaccess}};
        ram_en    = |ram_we;
        ram_addr  = address;
        ram_wdata = writedata;
      end else if (cpu_rd_go) begin
        ram_en   = 1'b1;
        ram_addr = address;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mon_addr       <= '0;
      MonDReg        <= '0;
      readdata       <= '0;
      ocimem_overrun <= 1'b0;
      pend_valid     <= 1'b0;
      pend_cmd       <= CMD_RD;
      pend_set       <= 1'b0;
      pend_addr      <= '0;
      pend_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_valid) begin
            pend_valid <= 1'b0;
            case (pend_cmd)
              CMD_RD: begin
                mon_addr <= jtag_addr;
                state    <= J_RD;
              end
              CMD_WR: begin
                mon_addr <= mon_addr + 1'b1;
                MonDReg  <= pend_data;
              end
              default: mon_addr <= pend_addr;
            endcase
          end else if (cpu_rd_go) begin
            state <= C_RD;
          end
        end
        J_RD: begin
          MonDReg <= ram_rdata;
          state   <= J_CAP;
        end
        J_CAP: begin
          mon_addr <= mon_addr + 1'b1;
          state    <= IDLE;
        end
        C_RD: begin
          readdata <= ram_rdata;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (strobe_lost) ocimem_overrun <= 1'b1;

      // A no-op 'a' (neither set-address nor read) still wins arbitration
      // but leaves the pending register empty.
      if (!pend_valid) begin
        if (take_action_ocimem_a) begin
          pend_valid <= jdo[SET_ADDR] | jdo[RD];
          pend_cmd   <= jdo[RD] ? CMD_RD : CMD_SETA;
          pend_set   <= jdo[SET_ADDR];
          pend_addr  <= jdo_addr;
        end else if (take_no_action_ocimem_a) begin
          pend_valid <= 1'b1;
          pend_cmd   <= CMD_RD;
          pend_set   <= 1'b0;
        end else if (take_action_ocimem_b) begin
          pend_valid <= 1'b1;
          pend_cmd   <= CMD_WR;
          pend_set   <= 1'b0;
          pend_data  <= jdo_data;
        end
      end
    end
  end

  led_chaser_ocimem_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_led_chaser_ocimem_ctrl.sv
// Bench for the debug-RAM controller: directed scenarios plus random JTAG/CPU
// traffic checked against a transaction-level model of RAM and monitor regs.
module tb_led_chaser_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [7:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic [9:0]  MonAReg;
  logic        ocimem_overrun;

  always #5 clk = ~clk;

  led_chaser_ocimem_ctrl dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .ocimem_overrun          (ocimem_overrun)
  );

  // reference model: RAM image plus the three monitor-visible registers
  logic [31:0] m_mem [256];
  int          m_addr = 0;
  logic [31:0] m_mon = '0;
  logic [31:0] m_rd = '0;
  logic        m_ovr = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [37:0] rand_jdo();
    return {6'($urandom), $urandom};
  endfunction

  task automatic jtag_a(input logic set, input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = rand_jdo();
    j[17] = set;
    j[34] = rd;
    j[33:26] = a;
    jdo = j;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    if (set) m_addr = int'(a);
    if (rd) begin
      m_mon = m_mem[m_addr];
      m_addr = (m_addr + 1) % 256;
      tick();
      tick();
      check_val("a_rd_mondreg", MonDReg, m_mon);
      tick();
    end else begin
      tick();
    end
    check_val("a_monareg", 32'(MonAReg), 32'(m_addr * 4));
  endtask

  task automatic jtag_na();
    jdo = rand_jdo();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    m_mon = m_mem[m_addr];
    m_addr = (m_addr + 1) % 256;
    tick();
    tick();
    check_val("na_mondreg", MonDReg, m_mon);
    tick();
    check_val("na_monareg", 32'(MonAReg), 32'(m_addr * 4));
  endtask

  task automatic jtag_b(input logic [31:0] d);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = d;
    jdo = j;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    m_mem[m_addr] = d;
    m_mon = d;
    m_addr = (m_addr + 1) % 256;
    tick();
    check_val("b_monareg", 32'(MonAReg), 32'(m_addr * 4));
    check_val("b_mondreg", MonDReg, m_mon);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic dbg);
    address = a;
    writedata = d;
    byteenable = be;
    debugaccess = dbg;
    write = 1'b1;
    #1;
    check_val("cpu_wr_wait", 32'(waitrequest), 32'd0);
    tick();
    write = 1'b0;
    if (dbg) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  // Counts cycles with waitrequest high before the read completes.
  task automatic cpu_read(input logic [7:0] a, input int exp_waits);
    int n;
    address = a;
    read = 1'b1;
    n = 0;
    #1;
    while (waitrequest && n < 20) begin
      n++;
      tick();
      #1;
    end
    tick();
    read = 1'b0;
    m_rd = m_mem[a];
    check_val("cpu_rd_waits", 32'(n), 32'(exp_waits));
    check_val("cpu_rd_data", readdata, m_rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d1, d2;
    logic [7:0]  tgt;
    int          n;

    tick();
    tick();
    #1;
    check_val("rst_mondreg", MonDReg, 32'd0);
    check_val("rst_monareg", 32'(MonAReg), 32'd0);
    check_val("rst_readdata", readdata, 32'd0);
    check_val("rst_overrun", 32'(ocimem_overrun), 32'd0);
    check_val("rst_wait", 32'(waitrequest), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 256; i++) cpu_write(8'(i), $urandom, 4'hF, 1'b1);

    // address load and read
    cpu_write(8'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    jtag_a(1'b1, 1'b1, 8'd5);
    check_val("load_rd_data", MonDReg, 32'hDEADBEEF);
    check_val("load_rd_addr", 32'(MonAReg), 32'h018);

    // write at top of RAM, wrap, then streaming read
    jtag_a(1'b1, 1'b0, 8'd255);
    check_val("set_addr_top", 32'(MonAReg), 32'h3FC);
    jtag_b(32'h12345678);
    check_val("wrap_addr", 32'(MonAReg), 32'h000);
    cpu_read(8'd255, 1);
    check_val("ram255", readdata, 32'h12345678);
    jtag_na();
    jtag_a(1'b0, 1'b0, 8'd77);

    // CPU write gating by debugaccess
    cpu_write(8'd3, 32'h00000000, 4'hF, 1'b1);
    cpu_write(8'd3, 32'hA5A5A5A5, 4'b0011, 1'b0);
    cpu_read(8'd3, 1);
    check_val("gate_off", readdata, 32'h00000000);
    cpu_write(8'd3, 32'hA5A5A5A5, 4'b0011, 1'b1);
    cpu_read(8'd3, 1);
    check_val("gate_on", readdata, 32'h0000A5A5);

    // collision: CPU read arrives while a JTAG write is pending
    jtag_a(1'b1, 1'b0, 8'd40);
    d1 = $urandom;
    jdo = rand_jdo();
    jdo[34:3] = d1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    m_mem[40] = d1;
    m_mon = d1;
    m_addr = 41;
    address = 8'd40;
    read = 1'b1;
    n = 0;
    #1;
    while (waitrequest && n < 20) begin
      n++;
      tick();
      #1;
    end
    tick();
    read = 1'b0;
    check_val("coll_waits", 32'(n), 32'd2);
    check_val("coll_data", readdata, d1);
    check_val("coll_addr", 32'(MonAReg), 32'(41 * 4));

    // overrun: second b strobe while the first is still pending
    check_val("ovr_before", 32'(ocimem_overrun), 32'd0);
    d1 = $urandom;
    d2 = $urandom;
    tgt = 8'(m_addr);
    jdo = rand_jdo();
    jdo[34:3] = d1;
    take_action_ocimem_b = 1'b1;
    tick();
    jdo[34:3] = d2;
    tick();
    take_action_ocimem_b = 1'b0;
    m_mem[tgt] = d1;
    m_mon = d1;
    m_addr = (m_addr + 1) % 256;
    m_ovr = 1'b1;
    check_val("ovr_set", 32'(ocimem_overrun), 32'(m_ovr));
    check_val("ovr_mondreg", MonDReg, d1);
    tick();
    tick();
    check_val("ovr_addr", 32'(MonAReg), 32'(m_addr * 4));
    cpu_read(tgt, 1);
    jtag_na();
    check_val("ovr_sticky", 32'(ocimem_overrun), 32'(m_ovr));

    // reset while a JTAG read sits in J_RD
    jdo = rand_jdo();
    jdo[17] = 1'b1;
    jdo[34] = 1'b1;
    jdo[33:26] = 8'd7;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_mondreg", MonDReg, 32'd0);
    check_val("mid_rst_monareg", 32'(MonAReg), 32'd0);
    check_val("mid_rst_readdata", readdata, 32'd0);
    check_val("mid_rst_overrun", 32'(ocimem_overrun), 32'd0);
    tick();
    reset_n = 1'b1;
    m_addr = 0;
    m_mon = '0;
    m_rd = '0;
    m_ovr = 1'b0;
    tick();
    cpu_read(8'd7, 1);
    cpu_read(8'd255, 1);
    jtag_na();

    // coincident strobes: no_action beats b, b is dropped
    jdo = rand_jdo();
    take_no_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    m_mon = m_mem[m_addr];
    m_addr = (m_addr + 1) % 256;
    m_ovr = 1'b1;
    tick();
    tick();
    check_val("coin_mondreg", MonDReg, m_mon);
    tick();
    check_val("coin_addr", 32'(MonAReg), 32'(m_addr * 4));
    check_val("coin_overrun", 32'(ocimem_overrun), 32'(m_ovr));

    // random traffic
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 5))
        0: jtag_a(1'($urandom), 1'($urandom), 8'($urandom));
        1: jtag_na();
        2: jtag_b($urandom);
        3: cpu_write(8'($urandom), $urandom, 4'($urandom), 1'($urandom));
        default: cpu_read(8'($urandom), 1);
      endcase
    end
    check_val("final_overrun", 32'(ocimem_overrun), 32'(m_ovr));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
